// File: rtl/axil_gpio_trig_pkg.sv
// Shared constants and types for the AXI4-Lite GPIO / trigger controller.
package axil_gpio_trig_pkg;

    // Register word index, i.e. byte offset >> 2 as decoded from addr[5:2]
    localparam logic [3:0] REG_OUT        = 4'h0;
    localparam logic [3:0] REG_IN         = 4'h1;
    localparam logic [3:0] REG_RISE_EN    = 4'h2;
    localparam logic [3:0] REG_FALL_EN    = 4'h3;
    localparam logic [3:0] REG_IRQ_STATUS = 4'h4;
    localparam logic [3:0] REG_IRQ_MASK   = 4'h5;
    localparam logic [3:0] REG_PULSE_W    = 4'h6;
    localparam logic [3:0] REG_PULSE_CTRL = 4'h7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/gpio_edge_capture.sv
// Input synchroniser, per-pin edge detection and write-1-to-clear interrupt status.
module gpio_edge_capture #(
    parameter int unsigned NUMB_INPUT_IO = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUMB_INPUT_IO-1:0] gpio_i,
    input  logic [NUMB_INPUT_IO-1:0] rise_en_i,
    input  logic [NUMB_INPUT_IO-1:0] fall_en_i,
    input  logic [NUMB_INPUT_IO-1:0] status_clr_i,
    output logic [NUMB_INPUT_IO-1:0] in_o,
    output logic [NUMB_INPUT_IO-1:0] status_o
);

    logic [NUMB_INPUT_IO-1:0] meta_q, meta_d;
    logic [NUMB_INPUT_IO-1:0] sync_q, sync_d;
    logic [NUMB_INPUT_IO-1:0] dly_q, dly_d;
    logic [NUMB_INPUT_IO-1:0] status_q, status_d;
    logic [NUMB_INPUT_IO-1:0] rise, fall;

    // Next state: shift pins through sync/delay stages and merge detected edges into status
    always_comb begin
        meta_d = gpio_i;
        sync_d = meta_q;
        dly_d  = sync_q;
        rise   = sync_q & ~dly_q;
        fall   = ~sync_q & dly_q;
        // A fresh edge wins over a clear of the same bit in the same cycle
        status_d = (status_q & ~status_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q   <= '0;
            sync_q   <= '0;
            dly_q    <= '0;
            status_q <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            status_q <= status_d;
        end
    end

    // IN reads the delay stage so it updates in the same cycle as the status bit it explains
    assign in_o     = dly_q;
    assign status_o = status_q;

endmodule

// File: rtl/axil_gpio_trig.sv
// AXI4-Lite GPIO and trigger controller: register file, pulse generator and maskable edge IRQ.
module axil_gpio_trig
    import axil_gpio_trig_pkg::*;
#(
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_ADDR_WIDTH = 11,
    parameter int unsigned NUMB_INPUT_IO   = 4,
    parameter int unsigned NUMB_OUTPUT_IO  = 3,
    parameter int unsigned PULSE_CNT_WIDTH = 16
) (
    input  logic                         aclk,
    input  logic                         aclk_reset_n,
    input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_awaddr,
    input  logic [2:0]                   aclk_awprot,
    input  logic                         aclk_awvalid,
    output logic                         aclk_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   aclk_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] aclk_wstrb,
    input  logic                         aclk_wvalid,
    output logic                         aclk_wready,
    output logic [1:0]                   aclk_bresp,
    output logic                         aclk_bvalid,
    input  logic                         aclk_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_araddr,
    input  logic [2:0]                   aclk_arprot,
    input  logic                         aclk_arvalid,
    output logic                         aclk_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   aclk_rdata,
    output logic [1:0]                   aclk_rresp,
    output logic                         aclk_rvalid,
    input  logic                         aclk_rready,
    input  logic [NUMB_INPUT_IO-1:0]     gpio_in,
    output logic [NUMB_OUTPUT_IO-1:0]    gpio_out,
    output logic                         irq
);

    // Bus handshake state
    logic                       aw_ready_q, aw_ready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       ar_ready_q, ar_ready_d;
    logic                       rvalid_q, rvalid_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Register file
    logic [NUMB_OUTPUT_IO-1:0]  out_q, out_d;
    logic [NUMB_INPUT_IO-1:0]   rise_en_q, rise_en_d;
    logic [NUMB_INPUT_IO-1:0]   fall_en_q, fall_en_d;
    logic [NUMB_INPUT_IO-1:0]   irq_mask_q, irq_mask_d;
    logic [PULSE_CNT_WIDTH-1:0] pulse_width_q, pulse_width_d;
    logic                       irq_q, irq_d;

    // Pulse generator
    pulse_state_e               pulse_state_q, pulse_state_d;
    logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [NUMB_OUTPUT_IO-1:0]  pulse_mask_q, pulse_mask_d;
    logic                       overrun_q, overrun_d;

    logic                      wr_en, rd_en;
    logic [3:0]                wr_idx, rd_idx;
    logic                      pulse_start, overrun_clr, pulse_idx_ok;
    logic [4:0]                pulse_idx;
    logic [NUMB_OUTPUT_IO-1:0] pulse_onehot;
    logic [NUMB_INPUT_IO-1:0]  status_clr, in_sync, irq_status;
    logic                      unused_inputs;

    assign wr_en     = aw_ready_q & aclk_awvalid & aclk_wvalid;
    assign rd_en     = ar_ready_q & aclk_arvalid;
    assign wr_idx    = aclk_awaddr[5:2];
    assign rd_idx    = aclk_araddr[5:2];
    assign pulse_idx = aclk_wdata[4:0];

    // Protection bits, strobes and undecoded address/data bits have no effect
    assign unused_inputs = ^{aclk_awprot, aclk_arprot, aclk_wstrb, aclk_awaddr, aclk_araddr,
                             aclk_wdata};

    gpio_edge_capture #(
        .NUMB_INPUT_IO(NUMB_INPUT_IO)
    ) u_edge_capture (
        .clk_i       (aclk),
        .rst_ni      (aclk_reset_n),
        .gpio_i      (gpio_in),
        .rise_en_i   (rise_en_q),
        .fall_en_i   (fall_en_q),
        .status_clr_i(status_clr),
        .in_o        (in_sync),
        .status_o    (irq_status)
    );

    // Write channel: accept address and data together, then hold the response until bready
    always_comb begin
        // Re-arm in the same cycle a pending response is consumed to sustain one write per two
        aw_ready_d    = aclk_awvalid & aclk_wvalid & ~aw_ready_q & (~bvalid_q | aclk_bready);
        bvalid_d      = bvalid_q & ~aclk_bready;
        bresp_d       = bresp_q;
        out_d         = out_q;
        rise_en_d     = rise_en_q;
        fall_en_d     = fall_en_q;
        irq_mask_d    = irq_mask_q;
        pulse_width_d = pulse_width_q;
        status_clr    = '0;
        pulse_start   = 1'b0;
        overrun_clr   = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_idx)
                REG_OUT:        out_d         = aclk_wdata[NUMB_OUTPUT_IO-1:0];
                REG_IN:         bresp_d       = RESP_SLVERR;
                REG_RISE_EN:    rise_en_d     = aclk_wdata[NUMB_INPUT_IO-1:0];
                REG_FALL_EN:    fall_en_d     = aclk_wdata[NUMB_INPUT_IO-1:0];
                REG_IRQ_STATUS: status_clr    = aclk_wdata[NUMB_INPUT_IO-1:0];
                REG_IRQ_MASK:   irq_mask_d    = aclk_wdata[NUMB_INPUT_IO-1:0];
                REG_PULSE_W:    pulse_width_d = aclk_wdata[PULSE_CNT_WIDTH-1:0];
                REG_PULSE_CTRL: begin
                    pulse_start = 1'b1;
                    overrun_clr = aclk_wdata[1];
                end
                default:        bresp_d       = RESP_SLVERR;
            endcase
        end
    end

    // Pulse generator: load width on start, count down, drop the pin after the last cycle
    always_comb begin
        pulse_idx_ok = (32'(pulse_idx) < NUMB_OUTPUT_IO);
        for (int unsigned i = 0; i < NUMB_OUTPUT_IO; i++) begin
            pulse_onehot[i] = (32'(pulse_idx) == i);
        end
        pulse_state_d = pulse_state_q;
        pulse_cnt_d   = pulse_cnt_q;
        pulse_mask_d  = pulse_mask_q;
        overrun_d     = overrun_q & ~overrun_clr;
        unique case (pulse_state_q)
            PULSE_IDLE: begin
                if (pulse_start && pulse_idx_ok && (pulse_width_q != '0)) begin
                    pulse_state_d = PULSE_ACTIVE;
                    pulse_cnt_d   = pulse_width_q;
                    pulse_mask_d  = pulse_onehot;
                end
            end
            PULSE_ACTIVE: begin
                // Overrun set takes priority over its own clear bit in the same write
                if (pulse_start) begin
                    overrun_d = 1'b1;
                end
                if (pulse_cnt_q == PULSE_CNT_WIDTH'(1)) begin
                    pulse_state_d = PULSE_IDLE;
                    pulse_cnt_d   = '0;
                    pulse_mask_d  = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PULSE_CNT_WIDTH'(1);
                end
            end
            default: pulse_state_d = PULSE_IDLE;
        endcase
    end

    // Read channel: register the selected word and hold it until rready
    always_comb begin
        ar_ready_d = aclk_arvalid & ~ar_ready_q & (~rvalid_q | aclk_rready);
        rvalid_d   = rvalid_q & ~aclk_rready;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (rd_idx)
                REG_OUT:        rdata_d[NUMB_OUTPUT_IO-1:0]  = out_q;
                REG_IN:         rdata_d[NUMB_INPUT_IO-1:0]   = in_sync;
                REG_RISE_EN:    rdata_d[NUMB_INPUT_IO-1:0]   = rise_en_q;
                REG_FALL_EN:    rdata_d[NUMB_INPUT_IO-1:0]   = fall_en_q;
                REG_IRQ_STATUS: rdata_d[NUMB_INPUT_IO-1:0]   = irq_status;
                REG_IRQ_MASK:   rdata_d[NUMB_INPUT_IO-1:0]   = irq_mask_q;
                REG_PULSE_W:    rdata_d[PULSE_CNT_WIDTH-1:0] = pulse_width_q;
                REG_PULSE_CTRL: rdata_d[1:0] = {overrun_q, pulse_state_q == PULSE_ACTIVE};
                default:        rresp_d = RESP_SLVERR;
            endcase
        end
    end

    // Interrupt level is registered from masked status
    always_comb begin
        irq_d = |(irq_status & irq_mask_q);
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aclk_reset_n) begin
            aw_ready_q    <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            ar_ready_q    <= 1'b0;
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
            out_q         <= '0;
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            irq_mask_q    <= '0;
            pulse_width_q <= '0;
            irq_q         <= 1'b0;
            pulse_state_q <= PULSE_IDLE;
            pulse_cnt_q   <= '0;
            pulse_mask_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            aw_ready_q    <= aw_ready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            ar_ready_q    <= ar_ready_d;
            rvalid_q      <= rvalid_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
            out_q         <= out_d;
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            irq_mask_q    <= irq_mask_d;
            pulse_width_q <= pulse_width_d;
            irq_q         <= irq_d;
            pulse_state_q <= pulse_state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            pulse_mask_q  <= pulse_mask_d;
            overrun_q     <= overrun_d;
        end
    end

    assign aclk_awready = aw_ready_q;
    assign aclk_wready  = aw_ready_q;
    assign aclk_bvalid  = bvalid_q;
    assign aclk_bresp   = bresp_q;
    assign aclk_arready = ar_ready_q;
    assign aclk_rvalid  = rvalid_q;
    assign aclk_rresp   = rresp_q;
    assign aclk_rdata   = rdata_q;
    assign gpio_out     = out_q | pulse_mask_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_axil_gpio_trig.sv
// Self-checking bench for axil_gpio_trig: scoreboarded bus responses plus cycle-exact pin checks.
module tb_axil_gpio_trig;

    localparam logic [10:0] A_OUT  = 11'h000;
    localparam logic [10:0] A_IN   = 11'h004;
    localparam logic [10:0] A_RISE = 11'h008;
    localparam logic [10:0] A_FALL = 11'h00C;
    localparam logic [10:0] A_STAT = 11'h010;
    localparam logic [10:0] A_MASK = 11'h014;
    localparam logic [10:0] A_PW   = 11'h018;
    localparam logic [10:0] A_PC   = 11'h01C;
    localparam logic [10:0] A_BAD0 = 11'h020;
    localparam logic [10:0] A_BAD1 = 11'h024;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        aclk = 1'b0;
    logic        aclk_reset_n;
    logic [10:0] aclk_awaddr, aclk_araddr;
    logic [2:0]  aclk_awprot, aclk_arprot;
    logic        aclk_awvalid, aclk_awready, aclk_wvalid, aclk_wready;
    logic [31:0] aclk_wdata, aclk_rdata;
    logic [3:0]  aclk_wstrb;
    logic [1:0]  aclk_bresp, aclk_rresp;
    logic        aclk_bvalid, aclk_bready, aclk_arvalid, aclk_arready;
    logic        aclk_rvalid, aclk_rready;
    logic [3:0]  gpio_in;
    logic [2:0]  gpio_out;
    logic        irq;

    typedef struct {
        string       tag;
        logic [1:0]  resp;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] wr_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 aclk = ~aclk;

    axil_gpio_trig #(
        .AXIL_DATA_WIDTH(32),
        .AXIL_ADDR_WIDTH(11),
        .NUMB_INPUT_IO  (4),
        .NUMB_OUTPUT_IO (3),
        .PULSE_CNT_WIDTH(16)
    ) dut (
        .aclk        (aclk),
        .aclk_reset_n(aclk_reset_n),
        .aclk_awaddr (aclk_awaddr),
        .aclk_awprot (aclk_awprot),
        .aclk_awvalid(aclk_awvalid),
        .aclk_awready(aclk_awready),
        .aclk_wdata  (aclk_wdata),
        .aclk_wstrb  (aclk_wstrb),
        .aclk_wvalid (aclk_wvalid),
        .aclk_wready (aclk_wready),
        .aclk_bresp  (aclk_bresp),
        .aclk_bvalid (aclk_bvalid),
        .aclk_bready (aclk_bready),
        .aclk_araddr (aclk_araddr),
        .aclk_arprot (aclk_arprot),
        .aclk_arvalid(aclk_arvalid),
        .aclk_arready(aclk_arready),
        .aclk_rdata  (aclk_rdata),
        .aclk_rresp  (aclk_rresp),
        .aclk_rvalid (aclk_rvalid),
        .aclk_rready (aclk_rready),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .irq         (irq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Response monitors: pop the expectation queued when the request was issued
    always @(negedge aclk) begin : mon_r
        rd_exp_t e;
        if (aclk_rvalid && aclk_rready) begin
            if (rd_q.size() == 0) begin
                check_val("rd_unexpected", 32'(aclk_rvalid), 32'h0);
            end else begin
                e = rd_q.pop_front();
                check_val({e.tag, "_rdata"}, aclk_rdata, e.data);
                check_val({e.tag, "_rresp"}, 32'(aclk_rresp), 32'(e.resp));
            end
        end
    end

    always @(negedge aclk) begin : mon_b
        logic [1:0] e;
        if (aclk_bvalid && aclk_bready) begin
            if (wr_q.size() == 0) begin
                check_val("b_unexpected", 32'(aclk_bvalid), 32'h0);
            end else begin
                e = wr_q.pop_front();
                check_val("bresp", 32'(aclk_bresp), 32'(e));
            end
        end
    end

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    // Returns one cycle after the handshake cycle, just past the clock edge
    task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                             input logic [1:0] resp);
        bit seen = 1'b0;
        wr_q.push_back(resp);
        aclk_awaddr  = addr;
        aclk_wdata   = data;
        aclk_awvalid = 1'b1;
        aclk_wvalid  = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = aclk_awready;
        end
        check_val("aw_handshake", 32'({seen, aclk_wready}), 32'h3);
        next_cycle();
        aclk_awvalid = 1'b0;
        aclk_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [10:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input string tag);
        bit seen = 1'b0;
        rd_q.push_back('{tag, resp, data});
        aclk_araddr  = addr;
        aclk_arvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = aclk_arready;
        end
        check_val({tag, "_ar"}, 32'(seen), 32'h1);
        next_cycle();
        aclk_arvalid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        // Reset with every valid raised
        aclk_reset_n = 1'b0;
        aclk_awaddr  = A_OUT;
        aclk_araddr  = A_OUT;
        aclk_awprot  = 3'b0;
        aclk_arprot  = 3'b0;
        aclk_wdata   = 32'h7;
        aclk_wstrb   = 4'hF;
        aclk_awvalid = 1'b1;
        aclk_wvalid  = 1'b1;
        aclk_arvalid = 1'b1;
        aclk_bready  = 1'b1;
        aclk_rready  = 1'b1;
        gpio_in      = 4'h0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_ready", 32'({aclk_awready, aclk_wready, aclk_arready}), 32'h0);
        check_val("rst_b", 32'({aclk_bvalid, aclk_bresp}), 32'h0);
        check_val("rst_r", 32'({aclk_rvalid, aclk_rresp}), 32'h0);
        check_val("rst_rdata", aclk_rdata, 32'h0);
        check_val("rst_pins", 32'({gpio_out, irq}), 32'h0);
        next_cycle();
        aclk_reset_n = 1'b1;
        aclk_awvalid = 1'b0;
        aclk_wvalid  = 1'b0;
        aclk_arvalid = 1'b0;
        next_cycle();

        // OUT register, upper bits dropped
        axi_write(A_OUT, 32'h5, OKAY);
        @(negedge aclk);
        check_val("out_t1", 32'(gpio_out), 32'h5);
        next_cycle();
        axi_read(A_OUT, 32'h5, OKAY, "out_rd");
        axi_write(A_OUT, 32'hFF, OKAY);
        axi_read(A_OUT, 32'h7, OKAY, "out_trunc");
        axi_write(A_OUT, 32'h0, OKAY);

        // Rising edge on pin 0 with interrupt enabled
        axi_write(A_RISE, 32'h1, OKAY);
        axi_write(A_MASK, 32'h1, OKAY);
        axi_write(A_FALL, 32'h30, OKAY);
        axi_read(A_RISE, 32'h1, OKAY, "rise_en");
        axi_read(A_FALL, 32'h0, OKAY, "fall_trunc");
        gpio_in[0] = 1'b1;
        repeat (4) @(negedge aclk);
        check_val("irq_e3", 32'(irq), 32'h0);
        @(negedge aclk);
        check_val("irq_e4", 32'(irq), 32'h1);
        next_cycle();
        axi_read(A_STAT, 32'h1, OKAY, "stat_rise");
        axi_read(A_IN, 32'h1, OKAY, "in_rd");
        axi_write(A_STAT, 32'h1, OKAY);
        @(negedge aclk);
        check_val("irq_clr_t1", 32'(irq), 32'h1);
        @(negedge aclk);
        check_val("irq_clr_t2", 32'(irq), 32'h0);
        next_cycle();

        // Falling edge with FALL_EN clear sets nothing
        gpio_in[0] = 1'b0;
        repeat (6) next_cycle();
        axi_read(A_STAT, 32'h0, OKAY, "stat_fall_off");
        @(negedge aclk);
        check_val("irq_fall_off", 32'(irq), 32'h0);
        next_cycle();

        // New edge on pin 1 lands in the same cycle as its W1C
        axi_write(A_RISE, 32'h3, OKAY);
        gpio_in[1] = 1'b1;
        repeat (6) next_cycle();
        axi_read(A_STAT, 32'h2, OKAY, "stat_pin1");
        gpio_in[1] = 1'b0;
        repeat (6) next_cycle();
        gpio_in[1] = 1'b1;
        next_cycle();
        axi_write(A_STAT, 32'h2, OKAY);
        axi_read(A_STAT, 32'h2, OKAY, "stat_race");
        @(negedge aclk);
        check_val("irq_masked", 32'(irq), 32'h0);
        next_cycle();
        axi_write(A_STAT, 32'h2, OKAY);
        axi_read(A_STAT, 32'h0, OKAY, "stat_clr");

        // Pulse exactly PULSE_WIDTH cycles on pin 2
        axi_write(A_PW, 32'h0001_0005, OKAY);
        axi_read(A_PW, 32'h5, OKAY, "pw_trunc");
        axi_write(A_PC, 32'h2, OKAY);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check_val("pulse_hi", 32'(gpio_out), 32'h4);
        end
        @(negedge aclk);
        check_val("pulse_end", 32'(gpio_out), 32'h0);
        next_cycle();

        // Busy during a pulse; a second start is ignored and flags overrun
        axi_write(A_PC, 32'h2, OKAY);
        axi_read(A_PC, 32'h1, OKAY, "pc_busy");
        axi_write(A_PC, 32'h2, OKAY);
        axi_read(A_PC, 32'h2, OKAY, "pc_overrun");
        @(negedge aclk);
        check_val("no_restart", 32'(gpio_out), 32'h0);
        next_cycle();
        axi_write(A_PC, 32'h1F, OKAY);
        axi_read(A_PC, 32'h0, OKAY, "pc_ovr_clr");
        axi_write(A_PW, 32'h0, OKAY);
        axi_write(A_PC, 32'h0, OKAY);
        @(negedge aclk);
        check_val("pw0_no_pulse", 32'(gpio_out), 32'h0);
        next_cycle();
        axi_read(A_PC, 32'h0, OKAY, "pw0_idle");

        // Out-of-map and read-only accesses
        axi_read(A_BAD1, 32'h0, SLVERR, "rd_bad");
        axi_write(A_IN, 32'hF, SLVERR);
        axi_read(A_IN, 32'h2, OKAY, "in_after_wr");
        axi_write(A_BAD0, 32'h1, SLVERR);
        axi_read(A_OUT, 32'h0, OKAY, "out_after_bad");

        // Response back-pressure: bvalid holds and no new write is accepted
        aclk_bready = 1'b0;
        axi_write(A_OUT, 32'h1, OKAY);
        wr_q.push_back(OKAY);
        aclk_awaddr  = A_OUT;
        aclk_wdata   = 32'h2;
        aclk_awvalid = 1'b1;
        aclk_wvalid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check_val("b_hold", 32'({aclk_bvalid, aclk_awready}), 32'h2);
        end
        check_val("out_hold", 32'(gpio_out), 32'h1);
        next_cycle();
        aclk_bready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = aclk_awready;
        end
        check_val("aw_after_hold", 32'(seen), 32'h1);
        next_cycle();
        aclk_awvalid = 1'b0;
        aclk_wvalid  = 1'b0;
        axi_read(A_OUT, 32'h2, OKAY, "out_after_hold");

        // Reset in the middle of a pulse
        axi_write(A_OUT, 32'h0, OKAY);
        axi_write(A_PW, 32'd20, OKAY);
        axi_write(A_PC, 32'h1, OKAY);
        @(negedge aclk);
        check_val("pulse_pre_rst", 32'(gpio_out), 32'h2);
        next_cycle();
        aclk_reset_n = 1'b0;
        @(negedge aclk);
        check_val("rst_same_cycle", 32'(gpio_out), 32'h2);
        @(negedge aclk);
        check_val("rst_drop", 32'(gpio_out), 32'h0);
        next_cycle();
        aclk_reset_n = 1'b1;
        repeat (3) next_cycle();

        check_val("rd_drain", 32'(rd_q.size()), 32'h0);
        check_val("wr_drain", 32'(wr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
